// File: rtl/mem_wb_pipe_if.sv
// mem_wb_pipe_if: bundle between the MEM stage and the MEM/WB pipeline register.
//   master : drives the MEM-stage signals and observes the WB results (MEM stage / bench)
//   slave  : samples the MEM-stage signals and drives the WB results (mem_wb_pipe)
// MEM -> WB : validIn, stall, flush, srcSel, dataFromALU, dataFromRam, pcPlus4,
//             immIn, loadSize, loadUnsigned, byteOffset, writeEnableIn, writeBackAddrIn
// WB -> RF  : validOut, writeEnableOut, writeBackAddrOut, dataToReg, retireCount
interface mem_wb_pipe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic                  validIn;
  logic                  stall;
  logic                  flush;
  logic [1:0]            srcSel;
  logic [DATA_W-1:0]     dataFromALU;
  logic [DATA_W-1:0]     dataFromRam;
  logic [DATA_W-1:0]     pcPlus4;
  logic [DATA_W-1:0]     immIn;
  logic [1:0]            loadSize;
  logic                  loadUnsigned;
  logic [OFF_W-1:0]      byteOffset;
  logic                  writeEnableIn;
  logic [REG_ADDR_W-1:0] writeBackAddrIn;

  logic                  validOut;
  logic                  writeEnableOut;
  logic [REG_ADDR_W-1:0] writeBackAddrOut;
  logic [DATA_W-1:0]     dataToReg;
  logic [CNT_W-1:0]      retireCount;

  modport master (
    output validIn, stall, flush, srcSel, dataFromALU, dataFromRam, pcPlus4,
           immIn, loadSize, loadUnsigned, byteOffset, writeEnableIn, writeBackAddrIn,
    input  validOut, writeEnableOut, writeBackAddrOut, dataToReg, retireCount
  );

  modport slave (
    input  validIn, stall, flush, srcSel, dataFromALU, dataFromRam, pcPlus4,
           immIn, loadSize, loadUnsigned, byteOffset, writeEnableIn, writeBackAddrIn,
    output validOut, writeEnableOut, writeBackAddrOut, dataToReg, retireCount
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline register with load alignment/extension,
// write-back source select and a retired-instruction counter.
//   clk     : rising-edge clock
//   resetIn : asynchronous active-high reset, clears all WB state
//   bus     : mem_wb_pipe_if slave modport (MEM-stage inputs, WB outputs)
// The interface instance must be built with the same DATA_W/REG_ADDR_W/CNT_W.
module mem_wb_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic        clk,
  input  logic        resetIn,
  mem_wb_pipe_if.slave bus
);

  logic                  valid_q, valid_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [DATA_W-1:0]     lane;
  logic [DATA_W-1:0]     mask;
  logic                  msb;
  logic [DATA_W-1:0]     load_val;
  logic [DATA_W-1:0]     src_val;

  // Bits shifted in from above the word read as zero.
  assign lane = bus.dataFromRam >> {bus.byteOffset, 3'b000};

  // Extension is done with a width mask so one expression covers every size;
  // a double on a 32-bit path degenerates to a word (mask all ones, msb bit 31).
  always_comb begin
    mask = '1;
    msb  = lane[DATA_W-1];
    case (bus.loadSize)
      2'b00: begin
        mask = DATA_W'(8'hFF);
        msb  = lane[7];
      end
      2'b01: begin
        mask = DATA_W'(16'hFFFF);
        msb  = lane[15];
      end
      2'b10: begin
        mask = DATA_W'(32'hFFFF_FFFF);
        msb  = lane[31];
      end
      default: begin
        mask = '1;
        msb  = lane[DATA_W-1];
      end
    endcase
    load_val = (lane & mask) | ((!bus.loadUnsigned && msb) ? ~mask : '0);
  end

  always_comb begin
    src_val = bus.dataFromALU;
    case (bus.srcSel)
      2'b00:   src_val = bus.dataFromALU;
      2'b01:   src_val = load_val;
      2'b10:   src_val = bus.pcPlus4;
      default: src_val = bus.immIn;
    endcase
  end

  // Stall has priority over flush; a flush seen during a stall is dropped.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (!bus.stall) begin
      if (bus.flush) begin
        valid_d = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        data_d  = '0;
      end else begin
        valid_d = bus.validIn;
        we_d    = bus.validIn && bus.writeEnableIn && (bus.writeBackAddrIn != '0);
        addr_d  = bus.writeBackAddrIn;
        data_d  = src_val;
        if (bus.validIn) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge resetIn) begin
    if (resetIn) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.validOut         = valid_q;
  assign bus.writeEnableOut   = we_q;
  assign bus.writeBackAddrOut = addr_q;
  assign bus.dataToReg        = data_q;
  assign bus.retireCount      = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed and randomized checks of mem_wb_pipe against an
// arithmetic reference model. A second instance with CNT_W=4 shares the
// stimulus to exercise counter wrap.
module tb_mem_wb_pipe;
  logic clk;
  logic resetIn;

  mem_wb_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(64)) if0 ();
  mem_wb_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4))  if4 ();

  mem_wb_pipe #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(64)) dut (
    .clk(clk), .resetIn(resetIn), .bus(if0.slave));
  mem_wb_pipe #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .resetIn(resetIn), .bus(if4.slave));

  assign if4.validIn         = if0.validIn;
  assign if4.stall           = if0.stall;
  assign if4.flush           = if0.flush;
  assign if4.srcSel          = if0.srcSel;
  assign if4.dataFromALU     = if0.dataFromALU;
  assign if4.dataFromRam     = if0.dataFromRam;
  assign if4.pcPlus4         = if0.pcPlus4;
  assign if4.immIn           = if0.immIn;
  assign if4.loadSize        = if0.loadSize;
  assign if4.loadUnsigned    = if0.loadUnsigned;
  assign if4.byteOffset      = if0.byteOffset;
  assign if4.writeEnableIn   = if0.writeEnableIn;
  assign if4.writeBackAddrIn = if0.writeBackAddrIn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit              m_valid;
  bit              m_we;
  int unsigned     m_addr;
  longint unsigned m_data;
  longint unsigned m_cnt;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned ref_load(input longint unsigned ram, input int size,
                                               input bit uns, input int off);
    longint unsigned lane, modv, v;
    int nbytes;
    lane   = ram >> (8 * off);
    nbytes = (size == 3) ? 4 : (1 << size);
    modv   = 64'd1 << (8 * nbytes);
    v      = lane % modv;
    if (!uns && v >= modv / 2) v = v - modv;
    return v & 64'hFFFF_FFFF;
  endfunction

  function automatic longint unsigned ref_src();
    case (if0.srcSel)
      2'd0:    return longint'(if0.dataFromALU);
      2'd1:    return ref_load(longint'(if0.dataFromRam), int'(if0.loadSize),
                               if0.loadUnsigned, int'(if0.byteOffset));
      2'd2:    return longint'(if0.pcPlus4);
      default: return longint'(if0.immIn);
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, longint'(if0.validOut), longint'(m_valid));
    chk({tag, ".we"},    longint'(if0.writeEnableOut), longint'(m_we));
    chk({tag, ".addr"},  longint'(if0.writeBackAddrOut), longint'(m_addr));
    chk({tag, ".data"},  longint'(if0.dataToReg), m_data);
    chk({tag, ".cnt"},   if0.retireCount, m_cnt);
    chk({tag, ".cnt4"},  longint'(if4.retireCount), m_cnt % 16);
  endtask

  // One clock: the model consumes the inputs present at the edge, then outputs are checked.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!resetIn && !if0.stall) begin
      if (if0.flush) begin
        m_valid = 0; m_we = 0; m_addr = 0; m_data = 0;
      end else begin
        m_valid = if0.validIn;
        m_we    = if0.validIn && if0.writeEnableIn && (if0.writeBackAddrIn != 0);
        m_addr  = int'(if0.writeBackAddrIn);
        m_data  = ref_src();
        if (if0.validIn) m_cnt++;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input bit st, input bit fl, input int sel,
                       input bit [31:0] alu, input bit [31:0] ram, input bit [31:0] pc,
                       input bit [31:0] imm, input int sz, input bit uns, input int off,
                       input bit we, input int rd);
    if0.validIn = v; if0.stall = st; if0.flush = fl; if0.srcSel = 2'(sel);
    if0.dataFromALU = alu; if0.dataFromRam = ram; if0.pcPlus4 = pc; if0.immIn = imm;
    if0.loadSize = 2'(sz); if0.loadUnsigned = uns; if0.byteOffset = 2'(off);
    if0.writeEnableIn = we; if0.writeBackAddrIn = 5'(rd);
  endtask

  task automatic drive_rand(input bit st, input bit fl);
    drive($urandom_range(0, 1) == 1, st, fl, int'($urandom_range(0, 3)), $urandom, $urandom,
          $urandom, $urandom, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)));
  endtask

  initial begin
    resetIn = 1'b1;
    drive(1, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 1, 7);
    model_reset();
    #1;
    check_all("reset_async");
    // clock running with live inputs while reset is held
    @(posedge clk); #1; check_all("reset_hold1");
    @(posedge clk); #1; check_all("reset_hold2");
    @(negedge clk);
    resetIn = 1'b0;

    // ALU path
    drive(1, 0, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 1, 5);
    tick("alu");
    chk("alu.data_const", longint'(if0.dataToReg), 64'h1234_5678);
    chk("alu.cnt_const", if0.retireCount, 64'd1);

    // loads
    drive(1, 0, 0, 1, 0, 32'h80F0_7F81, 0, 0, 0, 0, 3, 1, 6);
    tick("ld_b_s3");
    chk("ld_b_s3_const", longint'(if0.dataToReg), 64'hFFFF_FF80);
    drive(1, 0, 0, 1, 0, 32'h80F0_7F81, 0, 0, 0, 1, 1, 1, 7);
    tick("ld_b_u1");
    chk("ld_b_u1_const", longint'(if0.dataToReg), 64'h0000_007F);
    drive(1, 0, 0, 1, 0, 32'h80F0_7F81, 0, 0, 1, 0, 2, 1, 8);
    tick("ld_h_s2");
    chk("ld_h_s2_const", longint'(if0.dataToReg), 64'hFFFF_80F0);
    drive(1, 0, 0, 1, 0, 32'h80F0_7F81, 0, 0, 3, 0, 0, 1, 9);
    tick("ld_d_as_w");
    drive(1, 0, 0, 1, 0, 32'h80F0_7F81, 0, 0, 2, 0, 1, 1, 9);
    tick("ld_w_off1");

    // rd = 0: no write strobe, still retires
    drive(1, 0, 0, 2, 0, 0, 32'h104, 0, 0, 0, 0, 1, 0);
    tick("rd0");
    chk("rd0.we_const", longint'(if0.writeEnableOut), 64'd0);

    // immediate, then an invalid slot that still loads data/addr
    drive(1, 0, 0, 3, 0, 0, 0, 32'hABCD_E000, 0, 0, 0, 1, 12);
    tick("imm");
    drive(0, 0, 0, 0, 32'h5555_AAAA, 0, 0, 0, 0, 0, 0, 1, 13);
    tick("invalid");

    // stall three cycles with changing inputs, then flush+stall, then flush
    drive(1, 0, 0, 0, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 0, 1, 3);
    tick("pre_stall");
    for (int i = 0; i < 3; i++) begin
      drive_rand(1, 0);
      if0.validIn = 1'b1;
      tick("stall");
    end
    drive_rand(1, 1);
    tick("stall_flush");
    drive_rand(0, 1);
    if0.validIn = 1'b1;
    tick("flush");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive_rand($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      tick("rand");
    end

    // reset between edges after four retirements, with a stalled instruction held
    for (int i = 0; i < 4; i++) begin
      drive_rand(0, 0);
      if0.validIn = 1'b1;
      tick("pre_rst");
    end
    drive_rand(1, 0);
    #2;
    resetIn = 1'b1;
    model_reset();
    #1;
    check_all("mid_rst");
    resetIn = 1'b0;

    // 17 retirements wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive_rand(0, 0);
      if0.validIn = 1'b1;
      tick("wrap");
    end
    chk("wrap.cnt4_const", longint'(if4.retireCount), 64'd1);
    chk("wrap.cnt64_const", if0.retireCount, 64'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
